signal_activity_monitor: RTL
============================

Name: signal_activity_monitor

Overview:
- Parametrised N-channel runtime monitor that flags channels that never toggle during a programmable observation window. It is the hardware counterpart of the unused-variable lint rule: it reports idle or stuck signals with a sticky mask.
- Sits beside a DUT's control and status nets in debug/bring-up builds.
- Results are read through a valid/ready report handshake.

Parameters:
- NUM_CH, 8, number of monitored channels (1..64)
- WIN_W, 16, width of the window-length counter
- CNT_W, $clog2(NUM_CH+1), width of the idle-channel count (derived; do not override)

Ports:
- clk  input  1  clock; all logic is on the rising edge
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  begin a window; accepted only in IDLE, or in REPORT on the handshake cycle
- abort_i  input  1  cancel an active window (ARM/OBSERVE); no report is produced
- win_len_i  input  WIN_W  window length in cycles, sampled on start acceptance
- sig_i  input  NUM_CH  monitored signals, synchronous to clk
- busy_o  output  1  high in ARM and OBSERVE
- rpt_valid_o  output  1  report available
- rpt_ready_i  input  1  report consumer ready
- idle_mask_o  output  NUM_CH  bit set = channel did not toggle in the window
- idle_cnt_o  output  CNT_W  popcount of idle_mask_o

Behaviour:
- Reset values: busy_o=0, rpt_valid_o=0, idle_mask_o=0, idle_cnt_o=0. Internal state: FSM=IDLE, counter=0, seen flags=0, prev register=0.
- Reset asserted mid-window or mid-report discards everything and returns to IDLE on the next released edge.
- FSM states: IDLE, ARM, OBSERVE, REPORT.
- IDLE:
  - start_i=1 → ARM.
  - Counter loads max(win_len_i,1)-1; win_len_i=0 is treated as 1.
- ARM (1 cycle):
  - prev <= sig_i, seen <= 0.
  - → OBSERVE, or → IDLE if abort_i=1.
- OBSERVE:
  - Each cycle: seen <= seen | (sig_i ^ prev), then prev <= sig_i.
  - If counter==0, this is the last observed cycle: latch idle_mask_o <= ~(seen | (sig_i ^ prev)), latch idle_cnt_o, → REPORT. Otherwise decrement the counter.
  - abort_i=1 → IDLE. An abort takes priority over window completion in the same cycle.
  - start_i is ignored in OBSERVE.
- Window timing: exactly max(win_len_i,1) OBSERVE cycles. A toggle is detected only between consecutive samples starting from the ARM sample. rpt_valid_o rises on the cycle after the last OBSERVE cycle.
  - Total latency from start acceptance to rpt_valid_o = win_len+2 cycles (win_len≥1).
- REPORT:
  - rpt_valid_o=1; idle_mask_o and idle_cnt_o are held stable until the handshake.
  - Handshake (rpt_valid_o & rpt_ready_i): → ARM if start_i=1 in the same cycle (back-to-back; win_len_i sampled then), else → IDLE.
  - abort_i is ignored in REPORT.
- idle_mask_o and idle_cnt_o keep their last report values in IDLE/ARM/OBSERVE. They are only meaningful while rpt_valid_o=1.
- Counter width: WIN_W; the maximum window is 2^WIN_W-1 cycles. The counter never wraps because it only decrements until 0.
- idle_cnt_o = 0..NUM_CH. All channels idle gives NUM_CH, with no overflow because CNT_W covers NUM_CH.

Optional Feature:
- Macro: SIGNAL_ACTIVITY_MONITOR_STUCK_VAL_EN
- Defined:
  - Adds output stuck_val_o [NUM_CH], latched with idle_mask_o.
  - Each bit = the constant level of an idle channel (its ARM sample); the bit is 0 for non-idle channels.
  - Reset value 0; held stable through REPORT like idle_mask_o.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- NUM_CH=8; start_i with win_len_i=4; sig_i held 8'hA5 throughout → rpt_valid_o rises 6 cycles after start, idle_mask_o=8'hFF, idle_cnt_o=8; with the macro, stuck_val_o=8'hA5.
- win_len_i=10; toggle only ch0 and ch3 once mid-window → idle_mask_o=8'hF6, idle_cnt_o=6; with the macro, stuck_val_o=ARM sample & 8'hF6.
- Toggle ch7 exactly on the last OBSERVE cycle (win_len_i=3) → bit 7 clear in idle_mask_o; a toggle on the first cycle after REPORT entry does not change the latched mask.
- abort_i in the 2nd OBSERVE cycle → busy_o drops next cycle, no rpt_valid_o; a new start_i with win_len_i=0 → report after 3 cycles (window treated as 1).
- Hold rpt_ready_i=0 for 5 cycles in REPORT while sig_i toggles → mask and count are unchanged. Then assert rpt_ready_i with start_i=1 → ARM next cycle, busy_o=1, second report correct.
- Assert rst_n=0 mid-OBSERVE and mid-REPORT → asynchronously busy_o=0, rpt_valid_o=0, idle_mask_o=0, idle_cnt_o=0; after release, start_i is accepted normally.

Source files
------------

// File: rtl/signal_activity_monitor.sv
// N-channel activity monitor: reports channels that never toggled during a programmable window.
// Optional STUCK_VAL output (constant level of idle channels) enabled by SIGNAL_ACTIVITY_MONITOR_STUCK_VAL_EN.
module signal_activity_monitor #(
    parameter int NUM_CH = 8,
    parameter int WIN_W  = 16,
    parameter int CNT_W  = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WIN_W-1:0]  win_len_i,
    input  logic [NUM_CH-1:0] sig_i,
    output logic              busy_o,
    output logic              rpt_valid_o,
    input  logic              rpt_ready_i,
    output logic [NUM_CH-1:0] idle_mask_o,
    output logic [CNT_W-1:0]  idle_cnt_o
`ifdef SIGNAL_ACTIVITY_MONITOR_STUCK_VAL_EN
    ,
    output logic [NUM_CH-1:0] stuck_val_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_OBSERVE,
        ST_REPORT
    } state_t;

    state_t            state_reg;
    logic [WIN_W-1:0]  cnt_reg;
    logic [NUM_CH-1:0] seen_reg;
    logic [NUM_CH-1:0] prev_reg;
    logic              busy_reg;
    logic              rpt_valid_reg;
    logic [NUM_CH-1:0] mask_reg;
    logic [CNT_W-1:0]  idle_cnt_reg;

    logic [NUM_CH-1:0] seen_next;
    logic [NUM_CH-1:0] mask_next;
    logic [CNT_W-1:0]  pop_next;
    logic [WIN_W-1:0]  win_load;

    // A zero-length request still observes one cycle.
    assign win_load = (win_len_i == '0) ? '0 : win_len_i - WIN_W'(1);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign seen_next[gi] = seen_reg[gi] | (sig_i[gi] ^ prev_reg[gi]);
        assign mask_next[gi] = ~seen_next[gi];
    end

    always_comb begin
        pop_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop_next = pop_next + CNT_W'(mask_next[i]);
        end
    end

`ifdef SIGNAL_ACTIVITY_MONITOR_STUCK_VAL_EN
    logic [NUM_CH-1:0] stuck_reg;
    assign stuck_val_o = stuck_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuck_reg <= '0;
        end else if (state_reg == ST_OBSERVE && !abort_i && cnt_reg == '0) begin
            // An idle channel's current level equals its ARM sample.
            stuck_reg <= sig_i & mask_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            seen_reg      <= '0;
            prev_reg      <= '0;
            busy_reg      <= 1'b0;
            rpt_valid_reg <= 1'b0;
            mask_reg      <= '0;
            idle_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        state_reg <= ST_ARM;
                        cnt_reg   <= win_load;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_ARM: begin
                    prev_reg <= sig_i;
                    seen_reg <= '0;
                    if (abort_i) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= ST_OBSERVE;
                    end
                end
                ST_OBSERVE: begin
                    seen_reg <= seen_next;
                    prev_reg <= sig_i;
                    if (abort_i) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (cnt_reg == '0) begin
                        mask_reg      <= mask_next;
                        idle_cnt_reg  <= pop_next;
                        state_reg     <= ST_REPORT;
                        busy_reg      <= 1'b0;
                        rpt_valid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - WIN_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (rpt_ready_i) begin
                        rpt_valid_reg <= 1'b0;
                        if (start_i) begin
                            state_reg <= ST_ARM;
                            cnt_reg   <= win_load;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_reg;
    assign rpt_valid_o = rpt_valid_reg;
    assign idle_mask_o = mask_reg;
    assign idle_cnt_o  = idle_cnt_reg;

endmodule
